if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC and drives the IF->ID boundary (if_pc, if_inst) feeding the ID-stage pipeline register.
//  Issues one outstanding request at a time to a variable-latency instruction memory.
//  Absorbs pipeline stalls and branch/jump redirects. Raises if_busy so the hazard unit flushes ID while no instruction is ready.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
//  NOP_INST  32'h0000_0000  instruction driven on if_inst whenever if_valid=0
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  stall        in   1   hazard unit: ID not accepting; hold current instruction
//  redirect     in   1   EX/ID: taken branch/jump/exception; overrides stall
//  redirect_pc  in   32  new fetch target, sampled when redirect=1
//  imem_req     out  1   memory request; held until imem_ready
//  imem_addr    out  32  request address; stable while imem_req=1
//  imem_ready   in   1   memory: imem_rdata valid this cycle, request done
//  imem_rdata   in   32  fetched instruction
//  if_pc        out  32  PC of instruction on if_inst
//  if_inst      out  32  instruction to ID register; NOP_INST when !if_valid
//  if_valid     out  1   if_pc/if_inst valid this cycle
//  if_busy      out  1   = ~if_valid; hazard unit flushes ID register when 1
//  if_adel      out  1   misaligned-fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - pc=RESET_PC, req_addr=RESET_PC, hold_inst=NOP_INST, state=IDLE.
//   - imem_req=0, if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, if_adel=0.
//   - Reset mid-request abandons it; memory must tolerate the req drop.
//  Registers: pc (current fetch target), req_addr (address of abandoned request), hold_inst.
//  States:
//   - IDLE: imem_req=0; next FETCH (one cycle after rst_n deasserts).
//   - FETCH: imem_req=1, imem_addr=pc, if_pc=pc.
//     if_valid=imem_ready, if_inst=imem_rdata when ready.
//   - HOLD: imem_req=0; if_valid=1, if_pc=pc, if_inst=hold_inst.
//   - DISCARD: imem_req=1, imem_addr=req_addr, if_valid=0.
//     Waits for the abandoned request to finish; data dropped.
//  Transitions (redirect has highest priority, then stall):
//   - FETCH, redirect, !imem_ready: req_addr<=pc, pc<=redirect_pc -> DISCARD.
//   - FETCH, redirect, imem_ready: pc<=redirect_pc -> FETCH; data dropped, if_valid forced 0.
//   - FETCH, ready, !stall: pc<=pc+4 -> FETCH (back-to-back; 1 instr/cycle if memory always ready).
//   - FETCH, ready, stall: hold_inst<=imem_rdata -> HOLD.
//   - FETCH, !ready: stay; addr unchanged.
//   - HOLD, redirect: pc<=redirect_pc -> FETCH.
//   - HOLD, !stall: pc<=pc+4 -> FETCH.
//   - HOLD, stall: stay; outputs frozen.
//   - DISCARD, redirect: pc<=redirect_pc; stay. req_addr unchanged (latest target wins).
//   - DISCARD, imem_ready: -> FETCH at pc.
//  Latency: address issued to instruction presented = memory latency (0 extra cycles when ready same cycle).
//  Stall while !if_valid has no effect on state. pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0).
// CONFIGURATION
//  IF_ADDR_ERR_EN defined:
//   - In FETCH with pc[1:0]!=0: imem_req=0.
//   - Same cycle: if_valid=1, if_inst=NOP_INST, if_adel=1.
//   - Advances/holds exactly like a ready fetch (pc+4, or HOLD under stall; if_adel kept in HOLD).
//  IF_ADDR_ERR_EN undefined: if_adel tied 0; low PC bits passed to memory unchanged.
// TESTING
//  1. Reset release, imem_ready=1 always -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_valid=1 from first FETCH cycle.
//  2. imem_ready delayed 3 cycles -> imem_req/imem_addr=0x4 stable 3 cycles, if_busy=1; instruction presented once, then addr 0x8.
//  3. stall=1 for 2 cycles at if_pc=0x8 -> if_pc/if_inst frozen, imem_req=0; stall drops -> next addr 0xC.
//  4. redirect to 0x100 while 0xC waits -> addr 0xC held until ready, data dropped (if_valid=0); next request addr 0x100.
//  5. HOLD with stall=1 and redirect=1 to 0x200 together -> redirect wins; next cycle FETCH, imem_addr=0x200.
//  6. IF_ADDR_ERR_EN: redirect to 0x102 -> no imem_req; if_adel=1, if_inst=NOP_INST, if_pc=0x102; next pc 0x106.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time and presents if_pc/if_inst to ID.
// Optional misaligned-fetch detection is compiled in with `define IF_ADDR_ERR_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_busy,
  output logic        if_adel
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] hold_inst_reg, hold_inst_next;
  logic        adel_reg, adel_next;
  logic        misaligned;
  logic        fetch_done;
  logic [31:0] fetch_data;

`ifdef IF_ADDR_ERR_EN
  // A misaligned fetch never reaches memory; it completes at once with a NOP and the adel flag.
  assign misaligned = (state_reg == FETCH) && (pc_reg[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign fetch_done = misaligned | imem_ready;
  assign fetch_data = misaligned ? NOP_INST : imem_rdata;
  assign if_busy    = ~if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      req_addr_reg  <= RESET_PC;
      hold_inst_reg <= NOP_INST;
      adel_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_addr_reg  <= req_addr_next;
      hold_inst_reg <= hold_inst_next;
      adel_reg      <= adel_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_addr_next  = req_addr_reg;
    hold_inst_next = hold_inst_reg;
    adel_next      = adel_reg;
    imem_req       = 1'b0;
    imem_addr      = pc_reg;
    if_pc          = pc_reg;
    if_inst        = NOP_INST;
    if_valid       = 1'b0;
    if_adel        = 1'b0;

    case (state_reg)
      IDLE: state_next = FETCH;

      FETCH: begin
        imem_req = ~misaligned;
        if (redirect) begin
          pc_next = redirect_pc;
          // Request still in flight: remember its address so it can be drained.
          if (!fetch_done) begin
            req_addr_next = pc_reg;
            state_next    = DISCARD;
          end
        end else if (fetch_done) begin
          if_valid = 1'b1;
          if_inst  = fetch_data;
          if_adel  = misaligned;
          if (stall) begin
            hold_inst_next = fetch_data;
            adel_next      = misaligned;
            state_next     = HOLD;
          end else begin
            pc_next = pc_reg + 32'd4;
          end
        end
      end

      HOLD: begin
        if_valid = 1'b1;
        if_inst  = hold_inst_reg;
        if_adel  = adel_reg;
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else if (!stall) begin
          pc_next    = pc_reg + 32'd4;
          state_next = FETCH;
        end
      end

      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_reg;
        if (redirect) pc_next = redirect_pc;
        // Once the stale request completes nothing is outstanding, even if a new redirect arrived.
        if (imem_ready) state_next = FETCH;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, then random stall/redirect/latency checked against a program-order model.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, if_busy, if_adel;

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_busy(if_busy), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        s, r;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_adel;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic e_adel);
    vec_t v;
    v.s = s; v.r = r; v.rpc = rpc; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  // Random-phase memory model and program-order reference.
  logic        busy = 1'b0;
  logic [31:0] cur_addr = '0;
  int          wait_cnt = 0;
  logic [31:0] exp_next;
  int          idle_cnt;
  logic [31:0] e_inst;

  initial begin
    // s r rpc rdy | req addr valid pc adel
    add(0,0,32'h0,1,        1,32'h0,1,32'h0,0);
    add(0,0,32'h0,0,        1,32'h4,0,32'h0,0);
    add(0,0,32'h0,0,        1,32'h4,0,32'h0,0);
    add(0,0,32'h0,0,        1,32'h4,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'h4,1,32'h4,0);
    add(1,0,32'h0,1,        1,32'h8,1,32'h8,0);
    add(1,0,32'h0,0,        0,32'h8,1,32'h8,0);
    add(0,0,32'h0,0,        0,32'h8,1,32'h8,0);
    add(0,0,32'h0,0,        1,32'hC,0,32'h0,0);
    add(0,1,32'h100,0,      1,32'hC,0,32'h0,0);
    add(0,0,32'h0,0,        1,32'hC,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'hC,0,32'h0,0);
    add(1,0,32'h0,1,        1,32'h100,1,32'h100,0);
    add(1,1,32'h200,0,      0,32'h0,1,32'h100,0);
    add(0,0,32'h0,1,        1,32'h200,1,32'h200,0);
    add(0,1,32'h300,1,      1,32'h204,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'h300,1,32'h300,0);
    add(1,0,32'h0,0,        1,32'h304,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'h304,1,32'h304,0);
    add(0,1,32'hFFFF_FFFC,0,1,32'h308,0,32'h0,0);
    add(0,1,32'hFFFF_FFF8,0,1,32'h308,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'h308,0,32'h0,0);
    add(0,0,32'h0,1,        1,32'hFFFF_FFF8,1,32'hFFFF_FFF8,0);
    add(0,0,32'h0,1,        1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0);
    add(0,0,32'h0,1,        1,32'h0,1,32'h0,0);
`ifdef IF_ADDR_ERR_EN
    add(0,1,32'h102,1,      1,32'h4,0,32'h0,0);
    add(0,0,32'h0,0,        0,32'h0,1,32'h102,1);
    add(1,0,32'h0,0,        0,32'h0,1,32'h106,1);
    add(1,0,32'h0,0,        0,32'h0,1,32'h106,1);
    add(0,1,32'h400,0,      0,32'h0,1,32'h106,1);
    add(0,0,32'h0,1,        1,32'h400,1,32'h400,0);
`endif

    // Reset values.
    @(negedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_busy", 32'(if_busy), 32'd1);
    chk("rst_pc", if_pc, RESET_PC);
    chk("rst_inst", if_inst, NOP_INST);
    chk("rst_adel", 32'(if_adel), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_valid", 32'(if_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      stall = vecs[i].s; redirect = vecs[i].r; redirect_pc = vecs[i].rpc; imem_ready = vecs[i].rdy;
      imem_rdata = vecs[i].rdy ? mem_of(imem_addr) : 32'hBAD0_0000;
      #1;
      e_inst = (vecs[i].e_valid && !vecs[i].e_adel) ? mem_of(vecs[i].e_pc) : NOP_INST;
      $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h inst=%h adel=%0b", i, imem_req, imem_addr,
               if_valid, if_pc, if_inst, if_adel);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_busy", i), 32'(if_busy), 32'(!vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d_pc", i), if_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_inst", i), if_inst, e_inst);
      chk($sformatf("v%0d_adel", i), 32'(if_adel), 32'(vecs[i].e_adel));
    end

    // Asynchronous reset in the middle of activity.
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_pc", if_pc, RESET_PC);
    @(negedge clk); rst_n = 1'b1;
    busy = 1'b0; exp_next = RESET_PC; idle_cnt = 0;

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
`ifdef IF_ADDR_ERR_EN
      if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
`endif
      if (busy) begin
        chk("mem_req_held", 32'(imem_req), 32'd1);
        chk("mem_addr_stable", imem_addr, cur_addr);
      end else if (imem_req) begin
        busy = 1'b1; cur_addr = imem_addr; wait_cnt = $urandom_range(0, 3);
      end
      imem_ready = busy && (wait_cnt == 0);
      imem_rdata = imem_ready ? mem_of(cur_addr) : $urandom;
      #1;
      $display("rnd %0d: s=%0b r=%0b req=%0b addr=%h rdy=%0b valid=%0b pc=%h adel=%0b", c, stall,
               redirect, imem_req, imem_addr, imem_ready, if_valid, if_pc, if_adel);
      chk("rnd_busy", 32'(if_busy), 32'(!if_valid));
      if (!if_valid) chk("rnd_nop", if_inst, NOP_INST);
      else if (if_adel) begin
        chk("rnd_adel_inst", if_inst, NOP_INST);
        chk("rnd_adel_pc", 32'(if_pc[1:0] != 2'b00), 32'd1);
      end else chk("rnd_inst", if_inst, mem_of(if_pc));
      if (redirect) exp_next = redirect_pc;
      else if (if_valid && !stall) begin
        chk("rnd_order", if_pc, exp_next);
        exp_next = if_pc + 32'd4;
      end
      idle_cnt = (if_valid || redirect) ? 0 : idle_cnt + 1;
      chk("rnd_progress", 32'(idle_cnt > 12), 32'd0);
      @(posedge clk);
      if (imem_ready) busy = 1'b0;
      else if (busy) wait_cnt--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
